// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a rate-1/2 convolutional encoder: clears the encoder, streams
// data bits, appends the zero tail, and buffers returned symbols in a 4-entry FIFO.
module conv_frame_ctrl #(
  parameter int LEN_W      = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             choose_constraint_length,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             enc_bit,
  output logic             enc_en,
  output logic             enc_clr,
  input  logic [1:0]       sym_in,
  output logic [1:0]       out_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, CLR, DATA, TAIL, DRAIN} state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             k7_q;
  logic [2:0]       tcnt;
  logic             inflight;
  logic             inflight_last;
  logic             tail_last;
  logic             credit;
  logic             push;
  logic             pop;

  logic [1:0]       sym_mem  [FIFO_DEPTH];
  logic             last_mem [FIFO_DEPTH];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       occ;

  // Credit counts both buffered symbols and the one the encoder is still producing,
  // so the FIFO can never overflow and out_ready has no path to in_ready/enc_en.
  assign credit    = ({1'b0, occ} + {3'b000, inflight}) < 4'(FIFO_DEPTH);
  assign tail_last = (tcnt == (k7_q ? 3'd5 : 3'd1));

  always_comb begin
    in_ready = 1'b0;
    enc_en   = 1'b0;
    enc_bit  = 1'b0;
    if (state == DATA) begin
      in_ready = credit;
      enc_en   = credit & in_valid;
      enc_bit  = credit & in_valid & in_bit;
    end else if (state == TAIL) begin
      enc_en   = credit;
    end
  end

  assign enc_clr   = (state == CLR);
  assign busy      = (state != IDLE);
  assign push      = inflight;
  assign out_valid = (occ != 3'd0);
  assign pop       = out_valid & out_ready;
  assign out_sym   = sym_mem[rd_ptr];
  assign out_last  = out_valid & last_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      cnt           <= '0;
      k7_q          <= 1'b0;
      tcnt          <= 3'd0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= enc_en;
      inflight_last <= enc_en & (state == TAIL) & tail_last;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (frame_len != '0)) begin
            len_q <= frame_len;
            k7_q  <= choose_constraint_length;
            cnt   <= '0;
            tcnt  <= 3'd0;
            state <= CLR;
          end
        end
        CLR: state <= DATA;
        DATA: begin
          if (enc_en) begin
            if (cnt == len_q - LEN_W'(1)) begin
              cnt   <= '0;
              state <= TAIL;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        TAIL: begin
          if (enc_en) begin
            tcnt <= tcnt + 3'd1;
            if (tail_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((occ == 3'd0) && !inflight) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      sym_mem[wr_ptr]  <= sym_in;
      last_mem[wr_ptr] <= inflight_last;
    end
  end

endmodule
